// File: rtl/pipe_adder.sv
// pipe_adder
//   Pipelined integer add/subtract unit with a valid/ready handshake.
//   Stage k resolves operand bits [k*SEG +: SEG] using the registered carry
//   from stage k-1. Lower result segments ride along with their operation and
//   upper operand segments are carried forward, so every result bit leaves the
//   last stage in the same cycle. Latency is STAGES cycles and throughput is
//   one operation per cycle. The whole pipeline freezes while the output is
//   stalled.
//
//   Optional feature macro: PIPE_ADDER_SAT_EN
//     When defined, the in_sat port exists. If in_sat=1 and the operation
//     overflows, S is saturated to the signed limit in the final stage.
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   STAGES  pipeline depth, 1..WIDTH, must divide WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands A/B/Cin/sub (and in_sat) valid this cycle
//   in_ready   unit accepts an operation this cycle
//   A, B       operands
//   Cin        carry in, ignored when sub=1
//   sub        0: S=A+B+Cin   1: S=A-B
//   out_valid  S/Cout/Ovf hold a result
//   out_ready  consumer takes the result this cycle
//   S          sum/difference modulo 2^WIDTH
//   Cout       carry out of the MSB (under sub, 1 = no borrow)
//   Ovf        signed overflow
//   in_sat     saturate the signed result (PIPE_ADDER_SAT_EN only)

module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
`ifdef PIPE_ADDER_SAT_EN
    ,
    input  logic             in_sat
`endif
);

    localparam int SEG = WIDTH / STAGES;
    localparam int L   = STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipe_adder: illegal WIDTH/STAGES combination");
    end

    // Per-stage registers. a_q/b_q carry the not-yet-consumed operand
    // segments (b_q already holds B' = sub ? ~B : B), s_q the result bits
    // resolved so far, c_q the carry out of the segment just resolved.
    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             ovf_q;
`ifdef PIPE_ADDER_SAT_EN
    logic             sat_q   [STAGES];
    logic             sat_src [STAGES];
`endif

    // Inputs to each stage: the ports for stage 0, the previous register otherwise.
    logic             v_src [STAGES];
    logic             c_src [STAGES];
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];

    logic [WIDTH-1:0] s_nxt [STAGES];
    logic             c_nxt [STAGES];
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] s_fin;
    logic             ovf_nxt;
    logic             stall;

    assign out_valid = v_q[L];
    assign S         = s_q[L];
    assign Cout      = c_q[L];
    assign Ovf       = ovf_q;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        v_src[0] = in_valid;
        a_src[0] = A;
        b_src[0] = sub ? ~B : B;
        s_src[0] = '0;
        c_src[0] = sub ? 1'b1 : Cin;
`ifdef PIPE_ADDER_SAT_EN
        sat_src[0] = in_sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            v_src[k] = v_q[k-1];
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
`ifdef PIPE_ADDER_SAT_EN
            sat_src[k] = sat_q[k-1];
`endif
        end
    end

    // One SEG+1-bit add per stage; the top bit is the carry into the next segment.
    always_comb begin
        seg_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg_sum = {1'b0, a_src[k][k*SEG +: SEG]}
                    + {1'b0, b_src[k][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_src[k]};
            s_nxt[k]                = s_src[k];
            s_nxt[k][k*SEG +: SEG]  = seg_sum[SEG-1:0];
            c_nxt[k]                = seg_sum[SEG];
        end
    end

    // Overflow and optional saturation are resolved in the last stage, where
    // the full raw result first exists.
    always_comb begin
        ovf_nxt = (a_src[L][WIDTH-1] == b_src[L][WIDTH-1]) &&
                  (s_nxt[L][WIDTH-1] != a_src[L][WIDTH-1]);
        s_fin   = s_nxt[L];
`ifdef PIPE_ADDER_SAT_EN
        if (sat_src[L] && ovf_nxt) begin
            s_fin = a_src[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
`ifdef PIPE_ADDER_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_src[k];
                c_q[k] <= c_nxt[k];
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                s_q[k] <= (k == L) ? s_fin : s_nxt[k];
`ifdef PIPE_ADDER_SAT_EN
                sat_q[k] <= sat_src[k];
`endif
            end
            ovf_q <= ovf_nxt;
        end
    end

endmodule
